// File: rtl/uart_receiver.sv
// UART receive path: 2-FF input synchronizer, 16x-oversampled frame FSM and an RX FIFO
// with first-word-fall-through output, level threshold and sticky error flags.
module uart_receiver #(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       bclk,
    input  logic       rxd,
    input  logic       rx_en,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       read_en,
    input  logic       clr_err,
    input  logic [1:0] rx_thr_val,
    output logic [7:0] data_out,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       rx_thr,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_bclk_en
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t         state;
    logic [3:0]     tick_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           rxd_meta, rxd_s, rxd_d;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr, count;

    logic           sample_tick;
    logic           push_req, frame_bad, parity_bad;
    logic           do_push, do_pop;

    // rxd_d keeps the previous synchronized value for start-edge detection.
    // NOTE: sequential state is written only with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_d    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_d    <= rxd_s;
        end
    end

    assign sample_tick = bclk && (tick_cnt == TICK_LAST);
    assign push_req    = rx_en && (state == STOP) && sample_tick && rxd_s;
    assign frame_bad   = rx_en && (state == STOP) && sample_tick && !rxd_s;
    assign parity_bad  = rx_en && (state == PARITY) && sample_tick &&
                         (rxd_s != (parity_type ? ~^shift : ^shift));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else if (!rx_en) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rxd_d && !rxd_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (bclk) begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= rxd_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                DATA, PARITY, STOP: begin
                    if (bclk) begin
                        tick_cnt <= sample_tick ? 4'd0 : tick_cnt + 4'd1;
                    end
                    if (sample_tick) begin
                        case (state)
                            DATA: begin
                                shift[bit_idx] <= rxd_s;
                                if (bit_idx == 3'd7) begin
                                    state <= parity_en ? PARITY : STOP;
                                end else begin
                                    bit_idx <= bit_idx + 3'd1;
                                end
                            end
                            PARITY:  state <= STOP;
                            default: state <= IDLE;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_bclk_en = (state != IDLE);

    // A full FIFO still accepts a word when the head is popped on the same edge.
    assign do_pop  = read_en && !rx_empty;
    assign do_push = push_req && (!rx_full || do_pop);

    // NOTE: the storage array has no reset; pointers and count define validity and
    // data_out is forced to zero while empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= shift;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rx_empty = (count == '0);
    assign rx_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign data_out = rx_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        rx_thr = 1'b0;
        case (rx_thr_val)
            2'b00: rx_thr = (count >= (AW+1)'(1));
            2'b01: rx_thr = (count >= (AW+1)'(4));
            2'b10: rx_thr = (count >= (AW+1)'(8));
            2'b11: rx_thr = (count >= (AW+1)'(14));
            default: rx_thr = 1'b0;
        endcase
    end

    // Sticky flags: a new event on the same edge as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (parity_bad)           parity_err  <= 1'b1;
            else if (clr_err)         parity_err  <= 1'b0;
            if (frame_bad)            frame_err   <= 1'b1;
            else if (clr_err)         frame_err   <= 1'b0;
            if (push_req && !do_push) overrun_err <= 1'b1;
            else if (clr_err)         overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver: frames are driven bit by bit and
// compared against a queue-based model of the FIFO and sticky error flags.
module tb_uart_receiver;

    localparam int BIT_CLKS = 64;   // 16 bclk ticks, one every 4 clk

    logic       clk = 1'b0;
    logic       resetn;
    logic       bclk;
    logic       rxd;
    logic       rx_en;
    logic       parity_en;
    logic       parity_type;
    logic       read_en;
    logic       clr_err;
    logic [1:0] rx_thr_val;
    logic [7:0] data_out;
    logic       rx_empty, rx_full, rx_thr;
    logic       parity_err, frame_err, overrun_err, rx_bclk_en;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    logic       exp_par, exp_frm, exp_ovr;
    int         thr_tab[4] = '{1, 4, 8, 14};

    uart_receiver #(.FIFO_DEPTH(16), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bclk        (bclk),
        .rxd         (rxd),
        .rx_en       (rx_en),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .read_en     (read_en),
        .clr_err     (clr_err),
        .rx_thr_val  (rx_thr_val),
        .data_out    (data_out),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .rx_thr      (rx_thr),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .rx_bclk_en  (rx_bclk_en)
    );

    always #5 clk = ~clk;

    initial begin
        int bc = 0;
        bclk = 1'b0;
        forever begin
            @(negedge clk);
            bclk = (bc == 3);
            bc   = (bc + 1) % 4;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " rx_empty"},    rx_empty,    model_q.size() == 0);
        check({tag, " rx_full"},     rx_full,     model_q.size() == 16);
        check({tag, " data_out"},    data_out,    model_q.size() != 0 ? model_q[0] : 8'h00);
        check({tag, " parity_err"},  parity_err,  exp_par);
        check({tag, " frame_err"},   frame_err,   exp_frm);
        check({tag, " overrun_err"}, overrun_err, exp_ovr);
        check({tag, " rx_bclk_en"},  rx_bclk_en,  1'b0);
        for (int v = 0; v < 4; v++) begin
            rx_thr_val = 2'(v);
            #1;
            check($sformatf("%s rx_thr[%0d]", tag, v), rx_thr, model_q.size() >= thr_tab[v]);
        end
        rx_thr_val = 2'b00;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Drives one frame and updates the model from the framing rules.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (parity_en) drive_bit(pbit);
        drive_bit(stop);
        rxd = 1'b1;
        if (parity_en && ((($countones(d) + int'(pbit)) % 2) != int'(parity_type)))
            exp_par = 1'b1;
        if (!stop) exp_frm = 1'b1;
        else if (model_q.size() == 16) exp_ovr = 1'b1;
        else model_q.push_back(d);
    endtask

    task automatic pop_one(input string tag);
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
        check_state(tag);
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_par = 1'b0;
        exp_frm = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; rxd = 1'b1; rx_en = 1'b1; parity_en = 1'b0; parity_type = 1'b0;
        read_en = 1'b0; clr_err = 1'b0; rx_thr_val = 2'b00;
        exp_par = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
        repeat (5) @(negedge clk);
        check_state("reset");
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'hA5, 1'b0, 1'b1);
        check_state("a5_8n1");
        pop_one("a5_pop");

        parity_en = 1'b1; parity_type = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1);
        check_state("odd_bad");
        clear_errors();
        check_state("odd_clr");
        pop_one("odd_bad_pop");
        send_frame(8'h3C, 1'b1, 1'b1);
        check_state("odd_good");
        pop_one("odd_good_pop");
        parity_en = 1'b0;

        send_frame(8'h55, 1'b0, 1'b0);
        check_state("stop_low");
        clear_errors();

        rxd = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch busy", rx_bclk_en, 1'b1);
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check_state("glitch");

        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        rxd = 1'b1;
        rx_en = 1'b0;
        @(negedge clk);
        check("rx_en drop idle", rx_bclk_en, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        rx_en = 1'b1;
        check_state("rx_en drop");

        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b0, 1'b1);
            check_state($sformatf("fill%0d", i));
        end
        for (int i = 0; i < 16; i++) pop_one($sformatf("drain%0d", i));
        clear_errors();

        for (int n = 0; n < 24; n++) begin
            parity_en   = 1'($urandom);
            parity_type = 1'($urandom);
            send_frame(8'($urandom), 1'($urandom), $urandom_range(0, 7) != 0);
            check_state($sformatf("rand%0d", n));
            for (int k = $urandom_range(0, 2); k > 0; k--) pop_one($sformatf("rand_pop%0d", n));
            if ($urandom_range(0, 5) == 0) begin
                clear_errors();
                check_state($sformatf("rand_clr%0d", n));
            end
        end
        parity_en = 1'b0;

        send_frame(8'h77, 1'b0, 1'b1);
        send_frame(8'h12, 1'b0, 1'b0);
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
        rxd = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        model_q.delete();
        exp_par = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
        check_state("mid_reset");
        resetn = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        send_frame(8'h81, 1'b0, 1'b1);
        check_state("after_reset");
        pop_one("after_reset_pop");
        pop_one("empty_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
